// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer: default widths and FSM state encoding.
package prog_sequencer_pkg;

  localparam int unsigned SEQ_W_DEF = 8;
  localparam int unsigned SEQ_T_DEF = 10;
  localparam int unsigned SEQ_C_DEF = 16;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_FETCH   = 3'd1,
    SEQ_EXEC    = 3'd2,
    SEQ_MEMWAIT = 3'd3,
    SEQ_HALT    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/prog_sequencer_pc_next.sv
// Next program counter: branch/jump target when any strobe condition holds, else PC+1 with wrap.
module pc_next
  import prog_sequencer_pkg::*;
#(
  parameter int unsigned W = SEQ_W_DEF,
  parameter int unsigned T = SEQ_T_DEF
) (
  input  logic [T-1:0] pc_i,
  input  logic         branch_ez_i,
  input  logic         branch_nz_i,
  input  logic         branch_always_i,
  input  logic [W-1:0] cond_val_i,
  input  logic [W-1:0] reg_out_a_i,
  output logic [T-1:0] next_pc_c_o
);

  logic         cond_zero;
  logic         taken;
  logic [W+1:0] target_wide;

  // Targets are word addresses at 4-word alignment
  assign cond_zero   = (cond_val_i == '0);
  assign taken       = branch_always_i | (branch_ez_i & cond_zero) | (branch_nz_i & ~cond_zero);
  assign target_wide = {reg_out_a_i, 2'b00};
  assign next_pc_c_o = taken ? T'(target_wide) : pc_i + T'(1);

endmodule

// File: rtl/prog_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns PC, start/done handshake, load writeback cycle and cycle counter.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int unsigned W = SEQ_W_DEF,
  parameter int unsigned T = SEQ_T_DEF,
  parameter int unsigned C = SEQ_C_DEF
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [T-1:0] StartAddr,
  input  logic         BranchEZ,
  input  logic         BranchNZ,
  input  logic         BranchAlways,
  input  logic         Done_in,
  input  logic         IsLoad,
  input  logic [W-1:0] RegOutA,
  input  logic [W-1:0] CondVal,
  output logic [T-1:0] ProgCtr,
  output logic [T-1:0] ProgCtr_p4,
  output logic         Exec_en,
  output logic         Busy,
  output logic         Done,
  output logic [C-1:0] CycleCnt
);

  seq_state_e   state_q, state_d;
  logic [T-1:0] pc_q, pc_d;
  logic [C-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic [T-1:0] next_pc;

  pc_next #(
    .W(W),
    .T(T)
  ) u_pc_next (
    .pc_i           (pc_q),
    .branch_ez_i    (BranchEZ),
    .branch_nz_i    (BranchNZ),
    .branch_always_i(BranchAlways),
    .cond_val_i     (CondVal),
    .reg_out_a_i    (RegOutA),
    .next_pc_c_o    (next_pc)
  );

  // Next-state, datapath updates and the write-qualify strobe
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    Exec_en = 1'b0;

    if (busy_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + C'(1);
    end

    case (state_q)
      SEQ_IDLE: begin
        if (Start) begin
          pc_d    = StartAddr;
          cnt_d   = '0;
          state_d = SEQ_FETCH;
        end
      end
      SEQ_FETCH: begin
        state_d = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        if (Done_in) begin
          done_d  = 1'b1;
          state_d = SEQ_HALT;
        end else if (IsLoad) begin
          state_d = SEQ_MEMWAIT;
        end else begin
          Exec_en = 1'b1;
          pc_d    = next_pc;
          state_d = SEQ_FETCH;
        end
      end
      SEQ_MEMWAIT: begin
        Exec_en = 1'b1;
        pc_d    = next_pc;
        state_d = SEQ_FETCH;
      end
      SEQ_HALT: begin
        // Harness must drop Start before another run can begin
        if (!Start) begin
          done_d  = 1'b0;
          state_d = SEQ_IDLE;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

    busy_d = (state_d == SEQ_FETCH) || (state_d == SEQ_EXEC) || (state_d == SEQ_MEMWAIT);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= SEQ_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign ProgCtr    = pc_q;
  assign ProgCtr_p4 = pc_q + T'(4);
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign CycleCnt   = cnt_q;

endmodule
